// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the RV32I register file: two requesters share one write port,
// one registered write per cycle, plus a pending-write scoreboard for RAW stall detection.
module rf_wb_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_WAIT      = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_rd,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_rd,
  input  logic [31:0] req1_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        cu_rdwrite,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_in,
  output logic [31:0] pending
);

  localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

  logic        last_grant;
  logic [3:0]  wait_cnt;
  logic        grant0;
  logic        grant1;
  logic        xfer;
  logic [4:0]  win_rd;
  logic [31:0] win_data;
  logic [31:0] pending_nxt;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      if (req0_valid && req1_valid) begin
        if (PRIORITY_MODE == 0) begin
          grant0 = last_grant;
        end else begin
          grant0 = (wait_cnt == MAX_WAIT_L);
        end
        grant1 = !grant0;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 || grant1;
  assign win_rd     = grant1 ? req1_rd : req0_rd;
  assign win_data   = grant1 ? req1_data : req0_data;

  // A new issue to the same register outranks the retiring write, so set is applied last.
  always_comb begin
    pending_nxt = pending;
    if (xfer) begin
      pending_nxt[win_rd] = 1'b0;
    end
    if (issue_valid) begin
      pending_nxt[issue_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      wait_cnt   <= 4'd0;
      cu_rdwrite <= 1'b0;
      rd_addr    <= 5'd0;
      rd_in      <= 32'd0;
      pending    <= 32'd0;
    end else begin
      if (req0_valid && req1_valid) begin
        last_grant <= grant1;
      end
      if (grant0 || !req0_valid) begin
        wait_cnt <= 4'd0;
      end else begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      cu_rdwrite <= xfer && (win_rd != 5'd0);
      if (xfer) begin
        rd_addr <= win_rd;
        rd_in   <= win_data;
      end
      pending <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: round-robin and fixed-priority instances share stimulus,
// a per-cycle reference model feeds an expected-output queue checked after each edge.
module tb_rf_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid, issue_valid;
  logic [4:0]  req0_rd, req1_rd, issue_rd;
  logic [31:0] req0_data, req1_data;

  logic [1:0]  rdy0, rdy1, wen;
  logic [4:0]  addr [2];
  logic [31:0] wdat [2];
  logic [31:0] pend [2];

  always #5 clock = ~clock;

  rf_wb_arbiter #(.PRIORITY_MODE(0), .MAX_WAIT(4)) u0 (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(rdy0[0]), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(rdy1[0]), .req1_rd(req1_rd), .req1_data(req1_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .cu_rdwrite(wen[0]), .rd_addr(addr[0]), .rd_in(wdat[0]), .pending(pend[0])
  );

  rf_wb_arbiter #(.PRIORITY_MODE(1), .MAX_WAIT(4)) u1 (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(rdy0[1]), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(rdy1[1]), .req1_rd(req1_rd), .req1_data(req1_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .cu_rdwrite(wen[1]), .rd_addr(addr[1]), .rd_in(wdat[1]), .pending(pend[1])
  );

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pend;
  } exp_t;

  exp_t        exp_q [$];
  int          checks = 0;
  int          failures = 0;

  logic        m_last [2];
  int          m_wait [2];
  logic        m_wen  [2];
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];
  logic [31:0] m_pend [2];
  logic [31:0] rf [2][32];
  logic [15:0] gseq [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                       input logic iv, input logic [4:0] ir);
    exp_t e;
    reset_n = rst;
    req0_valid = v0; req0_rd = r0; req0_data = d0;
    req1_valid = v1; req1_rd = r1; req1_data = d1;
    issue_valid = iv; issue_rd = ir;
    #2;
    for (int k = 0; k < 2; k++) begin
      logic g0, g1;
      logic [4:0]  wrd;
      logic [31:0] wd;
      g0 = 1'b0;
      g1 = 1'b0;
      if (rst) begin
        if (v0 && v1) begin
          g0 = (k == 0) ? m_last[k] : (m_wait[k] == 4);
          g1 = !g0;
        end else begin
          g0 = v0;
          g1 = v1;
        end
      end
      check($sformatf("req0_ready_m%0d", k), {31'd0, rdy0[k]}, {31'd0, g0});
      check($sformatf("req1_ready_m%0d", k), {31'd0, rdy1[k]}, {31'd0, g1});
      gseq[k] = {gseq[k][14:0], g1};
      if (!rst) begin
        m_last[k] = 1'b1; m_wait[k] = 0; m_wen[k] = 1'b0;
        m_addr[k] = 5'd0; m_data[k] = 32'd0; m_pend[k] = 32'd0;
      end else begin
        if (v0 && v1) m_last[k] = g1;
        if (g0 || !v0) m_wait[k] = 0;
        else m_wait[k] = m_wait[k] + 1;
        wrd = g1 ? r1 : r0;
        wd  = g1 ? d1 : d0;
        if (g0 || g1) begin
          m_wen[k]  = (wrd != 5'd0);
          m_addr[k] = wrd;
          m_data[k] = wd;
          m_pend[k][wrd] = 1'b0;
        end else begin
          m_wen[k] = 1'b0;
        end
        if (iv) m_pend[k][ir] = 1'b1;
        m_pend[k][0] = 1'b0;
      end
      e.wen = m_wen[k]; e.addr = m_addr[k]; e.data = m_data[k]; e.pend = m_pend[k];
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      check($sformatf("cu_rdwrite_m%0d", k), {31'd0, wen[k]}, {31'd0, e.wen});
      check($sformatf("rd_addr_m%0d", k), {27'd0, addr[k]}, {27'd0, e.addr});
      check($sformatf("rd_in_m%0d", k), wdat[k], e.data);
      check($sformatf("pending_m%0d", k), pend[k], e.pend);
      if (wen[k]) rf[k][addr[k]] = wdat[k];
    end
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_last[k] = 1'b1; m_wait[k] = 0; m_wen[k] = 1'b0;
      m_addr[k] = 5'd0; m_data[k] = 32'd0; m_pend[k] = 32'd0; gseq[k] = 16'd0;
      for (int i = 0; i < 32; i++) rf[k][i] = 32'd0;
    end

    // reset held with both requesters and an issue active
    repeat (2) cycle(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 5'd9);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t1_wen_m%0d", k), {31'd0, wen[k]}, 32'd0);
      check($sformatf("t1_pending_m%0d", k), pend[k], 32'd0);
    end

    // single ALU write-back, then read back through the register-file model
    cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    idle();
    for (int k = 0; k < 2; k++)
      check($sformatf("t2_x5_m%0d", k), rf[k][5], 32'hDEADBEEF);

    // contention: both requesters hold steady requests
    repeat (4) cycle(1'b1, 1'b1, 5'd3, 32'hA0A0A0A0, 1'b1, 5'd4, 32'hB0B0B0B0, 1'b0, 5'd0);
    check("t3_rr_seq", {28'd0, gseq[0][3:0]}, 32'h5);
    check("t3_fixed_seq", {28'd0, gseq[1][3:0]}, 32'hF);
    idle();

    repeat (5) cycle(1'b1, 1'b1, 5'd3, 32'hA1A1A1A1, 1'b1, 5'd4, 32'hB1B1B1B1, 1'b0, 5'd0);
    check("t4_first_seq", {27'd0, gseq[1][4:0]}, 32'h1E);
    check("t4_wait_cleared", {28'd0, u1.wait_cnt}, 32'd0);
    repeat (5) cycle(1'b1, 1'b1, 5'd3, 32'hA1A1A1A1, 1'b1, 5'd4, 32'hB1B1B1B1, 1'b0, 5'd0);
    check("t4_full_seq", {22'd0, gseq[1][9:0]}, 32'h3DE);
    idle();

    // x0 handling and scoreboard set/clear
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t5_x0_nowrite_m%0d", k), {31'd0, wen[k]}, 32'd0);
      check($sformatf("t5_pending7_m%0d", k), pend[k], 32'h80);
    end
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 5'd0);
    for (int k = 0; k < 2; k++)
      check($sformatf("t5_pending_clr_m%0d", k), pend[k], 32'd0);

    // issue and retire of x9 collide; then reset lands mid-stream
    cycle(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
    for (int k = 0; k < 2; k++)
      check($sformatf("t6_set_wins_m%0d", k), {31'd0, pend[k][9]}, 32'd1);
    cycle(1'b1, 1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB, 1'b1, 5'd12);
    cycle(1'b0, 1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB, 1'b1, 5'd13);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t6_rst_wen_m%0d", k), {31'd0, wen[k]}, 32'd0);
      check($sformatf("t6_rst_pending_m%0d", k), pend[k], 32'd0);
    end
    cycle(1'b1, 1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB, 1'b0, 5'd0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
